demod_meas: RTL and testbench
=============================

Name: demod_meas

Overview:
- Measurement stage directly downstream of the AM/FM/PM demodulator.
- Consumes its AM and FM demod streams over a triggered window of samples, and tracks signed min/max of each.
- After the window, computes AM modulation index (max-min)/(max+min) with a sequential divider, plus FM peak-to-peak.
- Classifies modulation type and reports results to the control/display logic with a one-cycle done pulse.

Parameters:
- Data_width, 14, width of the signed AM_demod/FM_demod inputs.
- Win_len_width, 20, width of the window-length counter.
- Frac_bits, 10, fractional bits of AM_index (unsigned Q1.Frac_bits).
- AM_thr, 32, AM_index threshold for classifying AM (32 = 1/32 at Frac_bits=10).
- FM_thr, 64, FM_pp threshold for classifying FM.

Ports:
- clk_in  in  1  single system clock, all logic rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- meas_trigger  in  1  start request, sampled in IDLE only.
- win_len  in  Win_len_width  number of valid samples per window, latched at start.
- sample_valid  in  1  AM_demod/FM_demod valid this cycle.
- AM_demod  in  Data_width signed  amplitude demod sample.
- FM_demod  in  Data_width signed  frequency demod sample.
- busy  out  1  high from start until done cycle inclusive.
- done  out  1  one-cycle pulse when results update.
- AM_max, AM_min  out  Data_width signed  window extremes of AM_demod.
- FM_max, FM_min  out  Data_width signed  window extremes of FM_demod.
- AM_index  out  Frac_bits+1 unsigned  modulation index, saturates at 2^Frac_bits (1.0).
- FM_pp  out  Data_width+1 unsigned  FM_max-FM_min.
- mod_type  out  2  0=CW/none, 1=AM, 2=FM, 3=both.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs, counters and internal registers 0.
- Reset mid-operation aborts the measurement: no done pulse, outputs return to 0.
- FSM states: IDLE, CAPTURE, DIVIDE, DONE.
- IDLE -> CAPTURE when meas_trigger=1 and win_len!=0. On that edge:
  - latch win_len and clear the sample counter;
  - set running max regs to -2^(Data_width-1) and min regs to 2^(Data_width-1)-1.
- meas_trigger with win_len=0 is ignored and busy stays 0.
- meas_trigger outside IDLE is ignored and not queued.
- CAPTURE:
  - On each sample_valid=1 cycle, update all four running extremes (compare against the new sample, not the registered one) and increment the counter.
  - Cycles with sample_valid=0 do not count.
  - When the counter reaches latched win_len (the last valid sample is included), go to DIVIDE.
- DIVIDE:
  - num = AM_max-AM_min, unsigned Data_width+1 bits, always >=0.
  - den = AM_max+AM_min, signed Data_width+1 bits.
  - If den<=0 or num=0: quotient=0, and DIVIDE exits after one cycle.
  - Else if num>=den: quotient=2^Frac_bits (saturate), one cycle.
  - Else run a restoring divider for Frac_bits+1 cycles, one quotient bit per cycle, producing floor(num*2^Frac_bits/den).
- DONE (one cycle):
  - register AM_max/min, FM_max/min, AM_index, FM_pp = FM_max-FM_min;
  - mod_type = {FM_pp>FM_thr, AM_index>AM_thr};
  - done=1; next state IDLE.
- Outputs hold their last results until the next DONE.
- busy=1 in CAPTURE, DIVIDE, DONE.
- Latency from the trigger cycle to done, with continuous valid, normal divide: 1 + win_len + (Frac_bits+1) + 1 cycles. Fast paths replace Frac_bits+1 with 1.
- A new trigger is accepted the cycle after done.
- win_len=1 is legal: the single sample gives max=min.

Decomposition:
- Shared package demod_pkg holds:
  - the FSM state encoding (2 bits);
  - MOD_CW/MOD_AM/MOD_FM/MOD_BOTH codes.
- One sub-module, seq_divider: unsigned restoring divider with start/busy/done and a quotient width parameter. It is cleared by rst_n.
- Min/max tracking and the FSM stay in demod_meas.

Test Plan:
- AM tone: win_len=8, continuous valid, AM_demod alternating 3000/1000, FM_demod=0 -> done at cycle 1+8+11+1=21 after trigger; AM_max=3000, AM_min=1000, AM_index=512, FM_pp=0, mod_type=1.
- FM tone: win_len=16, AM_demod=2000 constant, FM_demod alternating +500/-500 -> AM_index=0 (num=0 fast path), FM_pp=1000, mod_type=2; done at cycle 1+16+1+1.
- Saturation: AM_demod alternating 3000/-1000 -> num=4000, den=2000, AM_index=1024; den<=0 case (100/-100) -> AM_index=0.
- Gaps: win_len=4, sample_valid high every other cycle -> only valid samples counted; done after the 4th valid sample + divide; a trigger pulsed during CAPTURE has no effect.
- win_len=0 trigger -> busy stays 0, no done, outputs unchanged.
- Reset: assert rst_n=0 mid-CAPTURE -> all outputs 0 immediately, no done; after release, a fresh win_len=2 measurement completes correctly.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared definitions for the demodulator measurement stage: FSM encoding and
// modulation-type codes.
package demod_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DIVIDE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [1:0] MOD_CW   = 2'd0;
   localparam logic [1:0] MOD_AM   = 2'd1;
   localparam logic [1:0] MOD_FM   = 2'd2;
   localparam logic [1:0] MOD_BOTH = 2'd3;

   function automatic logic [1:0] mod_code(input logic fm_hit, input logic am_hit);
      logic [1:0] code;
      case ({fm_hit, am_hit})
         2'b01:   code = MOD_AM;
         2'b10:   code = MOD_FM;
         2'b11:   code = MOD_BOTH;
         default: code = MOD_CW;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, QW cycles per divide.
// The first step is taken on the start edge itself, so quot is final when done pulses.
module seq_divider #(
   parameter int W  = 15,
   parameter int QW = 11
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W-1:0]  num,
   input  logic [W-1:0]  den,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] quot
);

   localparam int RW = W + 1;
   localparam int CW = $clog2(QW + 1);

   logic [RW-1:0] rem_r, rem_cur, rem_sub;
   logic [W-1:0]  den_r, den_cur;
   logic [QW-1:0] q_cur;
   logic [CW-1:0] cnt;
   logic          ge;

   always_comb begin
      rem_cur = start ? {1'b0, num} : rem_r;
      den_cur = start ? den : den_r;
      q_cur   = start ? '0 : quot;
      ge      = (rem_cur >= {1'b0, den_cur});
      rem_sub = ge ? (rem_cur - {1'b0, den_cur}) : rem_cur;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         rem_r <= '0;
         den_r <= '0;
         quot  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            // remainder stays below the divisor, so the dropped MSB is always zero
            rem_r <= {rem_sub[RW-2:0], 1'b0};
            den_r <= den_cur;
            quot  <= {q_cur[QW-2:0], ge};
            if (start) begin
               busy <= 1'b1;
               cnt  <= CW'(QW - 1);
            end else begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/demod_meas.sv
// Windowed AM/FM measurement: tracks signed extremes over win_len valid samples,
// then reports AM modulation index, FM peak-to-peak and a modulation-type guess.
module demod_meas
   import demod_pkg::*;
#(
   parameter int Data_width    = 14,
   parameter int Win_len_width = 20,
   parameter int Frac_bits     = 10,
   parameter int AM_thr        = 32,
   parameter int FM_thr        = 64
) (
   input  logic                           clk_in,
   input  logic                           rst_n,
   input  logic                           meas_trigger,
   input  logic [Win_len_width-1:0]       win_len,
   input  logic                           sample_valid,
   input  logic signed [Data_width-1:0]   AM_demod,
   input  logic signed [Data_width-1:0]   FM_demod,
   output logic                           busy,
   output logic                           done,
   output logic signed [Data_width-1:0]   AM_max,
   output logic signed [Data_width-1:0]   AM_min,
   output logic signed [Data_width-1:0]   FM_max,
   output logic signed [Data_width-1:0]   FM_min,
   output logic [Frac_bits:0]             AM_index,
   output logic [Data_width:0]            FM_pp,
   output logic [1:0]                     mod_type
);

   localparam int DW = Data_width;
   localparam int PW = Data_width + 1;
   localparam int IW = Frac_bits + 1;
   localparam int WW = Win_len_width;

   localparam logic signed [DW-1:0] S_MIN   = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] S_MAX   = {1'b0, {(DW-1){1'b1}}};
   localparam logic [IW-1:0]        IDX_SAT = {1'b1, {(IW-1){1'b0}}};
   localparam logic [IW-1:0]        AM_THR  = IW'(AM_thr);
   localparam logic [PW-1:0]        FM_THR  = PW'(FM_thr);

   state_t                state;
   logic [WW-1:0]         win_lat, cnt;
   logic signed [DW-1:0]  am_max_r, am_min_r, fm_max_r, fm_min_r;
   logic signed [DW-1:0]  am_max_nx, am_min_nx, fm_max_nx, fm_min_nx;
   logic signed [PW-1:0]  am_max_x, am_min_x, fm_max_x, fm_min_x;
   logic [PW-1:0]         num_nx, den_u, fm_pp_nx;
   logic signed [PW-1:0]  den_nx;
   logic                  last_smp, fast_zero, fast_sat, fast;
   logic [IW-1:0]         fast_q, idx_nx;
   logic                  div_start, div_busy, div_done;
   logic [IW-1:0]         div_q;

   // Extremes including the sample on the bus this cycle, so the window's final
   // sample feeds the divider operands on the same edge it is captured.
   always_comb begin
      am_max_nx = (AM_demod > am_max_r) ? AM_demod : am_max_r;
      am_min_nx = (AM_demod < am_min_r) ? AM_demod : am_min_r;
      fm_max_nx = (FM_demod > fm_max_r) ? FM_demod : fm_max_r;
      fm_min_nx = (FM_demod < fm_min_r) ? FM_demod : fm_min_r;
      am_max_x  = am_max_nx;
      am_min_x  = am_min_nx;
      fm_max_x  = fm_max_r;
      fm_min_x  = fm_min_r;
      num_nx    = am_max_x - am_min_x;
      den_nx    = am_max_x + am_min_x;
      den_u     = den_nx;
      fm_pp_nx  = fm_max_x - fm_min_x;
      fast_zero = (den_nx <= 0) || (num_nx == '0);
      fast_sat  = (num_nx >= den_u);
      last_smp  = (state == S_CAPTURE) && sample_valid && ((cnt + WW'(1)) == win_lat);
      div_start = last_smp && !fast_zero && !fast_sat && !div_busy;
      idx_nx    = fast ? fast_q : div_q;
   end

   seq_divider #(
      .W  (PW),
      .QW (IW)
   ) u_div (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .start  (div_start),
      .num    (num_nx),
      .den    (den_u),
      .busy   (div_busy),
      .done   (div_done),
      .quot   (div_q)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         win_lat  <= '0;
         cnt      <= '0;
         am_max_r <= '0;
         am_min_r <= '0;
         fm_max_r <= '0;
         fm_min_r <= '0;
         fast     <= 1'b0;
         fast_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         AM_max   <= '0;
         AM_min   <= '0;
         FM_max   <= '0;
         FM_min   <= '0;
         AM_index <= '0;
         FM_pp    <= '0;
         mod_type <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (meas_trigger && (win_len != '0)) begin
                  state    <= S_CAPTURE;
                  win_lat  <= win_len;
                  cnt      <= '0;
                  am_max_r <= S_MIN;
                  am_min_r <= S_MAX;
                  fm_max_r <= S_MIN;
                  fm_min_r <= S_MAX;
                  fast     <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (sample_valid) begin
                  am_max_r <= am_max_nx;
                  am_min_r <= am_min_nx;
                  fm_max_r <= fm_max_nx;
                  fm_min_r <= fm_min_nx;
                  cnt      <= cnt + WW'(1);
                  if (last_smp) begin
                     state  <= S_DIVIDE;
                     fast   <= fast_zero || fast_sat;
                     fast_q <= fast_zero ? '0 : IDX_SAT;
                  end
               end
            end
            S_DIVIDE: begin
               if (fast || div_done) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  AM_max   <= am_max_r;
                  AM_min   <= am_min_r;
                  FM_max   <= fm_max_r;
                  FM_min   <= fm_min_r;
                  AM_index <= idx_nx;
                  FM_pp    <= fm_pp_nx;
                  mod_type <= mod_code(fm_pp_nx > FM_THR, idx_nx > AM_THR);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demod_meas.sv
// Bench for demod_meas: directed table vectors, reset/abort and win_len=0 sequences,
// and randomized windows checked against a plain-arithmetic reference model.
module tb_demod_meas;

   localparam int DW = 14;
   localparam int WW = 20;
   localparam int FB = 10;

   logic                 clk_in = 1'b0;
   logic                 rst_n;
   logic                 meas_trigger;
   logic [WW-1:0]        win_len;
   logic                 sample_valid;
   logic signed [DW-1:0] AM_demod, FM_demod;
   logic                 busy, done;
   logic signed [DW-1:0] AM_max, AM_min, FM_max, FM_min;
   logic [FB:0]          AM_index;
   logic [DW:0]          FM_pp;
   logic [1:0]           mod_type;

   int n_tests = 0;
   int n_fail  = 0;
   int am_q[$];
   int fm_q[$];

   typedef struct {
      int wl; int gap; bit mid;
      int am_a; int am_b; int fm_a; int fm_b;
      int amax; int amin; int fmax; int fmin; int idx; int pp; int mt; int lat;
   } vec_t;

   vec_t vecs[7];

   demod_meas dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .meas_trigger (meas_trigger),
      .win_len      (win_len),
      .sample_valid (sample_valid),
      .AM_demod     (AM_demod),
      .FM_demod     (FM_demod),
      .busy         (busy),
      .done         (done),
      .AM_max       (AM_max),
      .AM_min       (AM_min),
      .FM_max       (FM_max),
      .FM_min       (FM_min),
      .AM_index     (AM_index),
      .FM_pp        (FM_pp),
      .mod_type     (mod_type)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference: extremes by scanning the window, index by integer division.
   function automatic vec_t model(input int wl, input int gap);
      vec_t e;
      int num, den;
      bit fast;
      e.wl = wl; e.gap = gap; e.mid = 1'b0;
      e.am_a = 0; e.am_b = 0; e.fm_a = 0; e.fm_b = 0;
      e.amax = -100000; e.amin = 100000; e.fmax = -100000; e.fmin = 100000;
      for (int i = 0; i < wl; i++) begin
         if (am_q[i] > e.amax) e.amax = am_q[i];
         if (am_q[i] < e.amin) e.amin = am_q[i];
         if (fm_q[i] > e.fmax) e.fmax = fm_q[i];
         if (fm_q[i] < e.fmin) e.fmin = fm_q[i];
      end
      num  = e.amax - e.amin;
      den  = e.amax + e.amin;
      fast = 1'b1;
      if (den <= 0 || num == 0)  e.idx = 0;
      else if (num >= den)       e.idx = 1 << FB;
      else begin
         e.idx = (num * (1 << FB)) / den;
         fast  = 1'b0;
      end
      e.pp  = e.fmax - e.fmin;
      e.mt  = ((e.pp > 64) ? 2 : 0) + ((e.idx > 32) ? 1 : 0);
      e.lat = 1 + (1 + (wl - 1) * gap) + (fast ? 1 : FB + 1) + 1;
      return e;
   endfunction

   // Trigger one window, feed am_q/fm_q with valid every gap cycles, return the
   // cycle (trigger cycle = 1) on which done is seen, or -1 on timeout.
   task automatic do_run(input int wl, input int gap, input bit mid, input string tag,
                         output int lat);
      int k;
      int idx;
      k = 0; idx = 0; lat = -1;
      @(negedge clk_in);
      meas_trigger = 1'b1;
      win_len      = WW'(wl);
      sample_valid = 1'b0;
      while (lat < 0 && k < 200) begin
         @(negedge clk_in);
         k++;
         if (k == 1) chk({tag, ".busy_start"}, int'(busy), 1);
         if (done) begin
            lat = k + 1;
            chk({tag, ".busy_at_done"}, int'(busy), 1);
         end
         meas_trigger = mid && (k == 2);
         if (idx < wl && ((k - 1) % gap) == 0) begin
            sample_valid = 1'b1;
            AM_demod     = DW'(am_q[idx]);
            FM_demod     = DW'(fm_q[idx]);
            idx++;
         end else begin
            sample_valid = 1'b0;
         end
      end
      meas_trigger = 1'b0;
      sample_valid = 1'b0;
      @(negedge clk_in);
      chk({tag, ".done_pulse"}, int'(done), 0);
      chk({tag, ".busy_after"}, int'(busy), 0);
      if (mid) begin
         @(negedge clk_in);
         chk({tag, ".no_requeue"}, int'(busy), 0);
      end
   endtask

   task automatic check_res(input string tag, input vec_t e, input int lat);
      chk({tag, ".latency"},  lat,            e.lat);
      chk({tag, ".am_max"},   int'(AM_max),   e.amax);
      chk({tag, ".am_min"},   int'(AM_min),   e.amin);
      chk({tag, ".fm_max"},   int'(FM_max),   e.fmax);
      chk({tag, ".fm_min"},   int'(FM_min),   e.fmin);
      chk({tag, ".am_index"}, int'(AM_index), e.idx);
      chk({tag, ".fm_pp"},    int'(FM_pp),    e.pp);
      chk({tag, ".mod_type"}, int'(mod_type), e.mt);
   endtask

   initial begin
      int   lat;
      bit   seen_done, seen_busy;
      vec_t e;

      vecs[0] = '{8,  1, 1'b0, 3000, 1000, 0, 0,        3000, 1000, 0, 0,        512,  0,     1, 21};
      vecs[1] = '{16, 1, 1'b0, 2000, 2000, 500, -500,   2000, 2000, 500, -500,   0,    1000,  2, 19};
      vecs[2] = '{4,  1, 1'b0, 3000, -1000, 0, 0,       3000, -1000, 0, 0,       1024, 0,     1, 7};
      vecs[3] = '{4,  1, 1'b0, 100, -100, 0, 0,         100, -100, 0, 0,         0,    0,     0, 7};
      vecs[4] = '{4,  2, 1'b1, 3000, 1000, 100, -100,   3000, 1000, 100, -100,   512,  200,   3, 20};
      vecs[5] = '{1,  1, 1'b0, 1500, 1500, -7, -7,      1500, 1500, -7, -7,      0,    0,     0, 4};
      vecs[6] = '{2,  1, 1'b0, -8192, 8191, -8192, 8191, 8191, -8192, 8191, -8192, 0,  16383, 2, 5};

      rst_n = 1'b0; meas_trigger = 1'b0; win_len = '0; sample_valid = 1'b0;
      AM_demod = '0; FM_demod = '0;
      repeat (2) @(negedge clk_in);
      chk("reset.busy",     int'(busy),     0);
      chk("reset.done",     int'(done),     0);
      chk("reset.am_max",   int'(AM_max),   0);
      chk("reset.am_index", int'(AM_index), 0);
      chk("reset.mod_type", int'(mod_type), 0);
      rst_n = 1'b1;

      foreach (vecs[v]) begin
         am_q.delete(); fm_q.delete();
         for (int i = 0; i < vecs[v].wl; i++) begin
            am_q.push_back((i % 2) ? vecs[v].am_b : vecs[v].am_a);
            fm_q.push_back((i % 2) ? vecs[v].fm_b : vecs[v].fm_a);
         end
         do_run(vecs[v].wl, vecs[v].gap, vecs[v].mid, $sformatf("vec%0d", v), lat);
         check_res($sformatf("vec%0d", v), vecs[v], lat);
      end

      // win_len=0 trigger must be ignored and leave the last results alone
      @(negedge clk_in);
      meas_trigger = 1'b1; win_len = '0;
      seen_done = 1'b0; seen_busy = 1'b0;
      repeat (4) begin
         @(negedge clk_in);
         meas_trigger = 1'b0;
         seen_done |= done;
         seen_busy |= busy;
      end
      chk("wl0.busy",   int'(seen_busy), 0);
      chk("wl0.done",   int'(seen_done), 0);
      chk("wl0.am_max", int'(AM_max),    8191);
      chk("wl0.fm_pp",  int'(FM_pp),     16383);

      // abort a capture with reset
      @(negedge clk_in);
      meas_trigger = 1'b1; win_len = WW'(8);
      @(negedge clk_in);
      meas_trigger = 1'b0; sample_valid = 1'b1; AM_demod = DW'(700); FM_demod = DW'(-30);
      repeat (2) @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      chk("abort.busy",     int'(busy),     0);
      chk("abort.am_max",   int'(AM_max),   0);
      chk("abort.fm_min",   int'(FM_min),   0);
      chk("abort.am_index", int'(AM_index), 0);
      chk("abort.fm_pp",    int'(FM_pp),    0);
      chk("abort.mod_type", int'(mod_type), 0);
      sample_valid = 1'b0;
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         seen_done |= done;
      end
      chk("abort.no_done", int'(seen_done), 0);
      rst_n = 1'b1;
      am_q = '{1000, 300};
      fm_q = '{40, -40};
      e = '{2, 1, 1'b0, 0, 0, 0, 0, 1000, 300, 40, -40, 551, 80, 3, 15};
      do_run(2, 1, 1'b0, "post_rst", lat);
      check_res("post_rst", e, lat);

      for (int r = 0; r < 25; r++) begin
         int wl, gap, mode, base, dev, fdev;
         bit mid;
         wl   = int'($urandom_range(1, 24));
         gap  = int'($urandom_range(1, 3));
         mid  = bit'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 2));
         base = int'($urandom_range(500, 4000));
         dev  = int'($urandom_range(0, base));
         fdev = int'($urandom_range(0, 150));
         am_q.delete(); fm_q.delete();
         for (int i = 0; i < wl; i++) begin
            case (mode)
               0:       am_q.push_back(int'($urandom_range(0, 16383)) - 8192);
               1:       am_q.push_back(base + int'($urandom_range(0, 2 * dev)) - dev);
               default: am_q.push_back(base);
            endcase
            fm_q.push_back(int'($urandom_range(0, 2 * fdev)) - fdev);
         end
         e = model(wl, gap);
         do_run(wl, gap, mid, $sformatf("rnd%0d", r), lat);
         check_res($sformatf("rnd%0d", r), e, lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
